// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register names,
// memory-wait FSM states and default sizing constants.
package pipeline_hazard_ctrl_pkg;

  typedef logic [4:0] regName_t;

  localparam regName_t REG_ZERO = 5'd0;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazState_t;

  // True when an ID source operand is live and names the given register.
  function automatic logic src_hit(input logic used, input regName_t rs, input regName_t rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: tracks outstanding accesses, counts wait cycles
// and latches a sticky error when the memory never acknowledges.
module hazard_mem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  output logic mem_stall,
  output logic mem_err,
  output logic in_error
);

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  hazState_t  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // The stall is raised in the request cycle itself so the pipeline never
  // advances past an unacknowledged access.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    mem_stall  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          mem_stall  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == LAST_WAIT) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ERROR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign mem_err  = mem_err_q;
  assign in_error = (state_q == ERROR);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional stall counter is
// built only when HAZARD_STALL_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  regName_t         rs1_Id,
  input  regName_t         rs2_Id,
  input  logic             rs1Used_Id,
  input  logic             rs2Used_Id,
  input  regName_t         rd_Ex,
  input  logic             memRead_Ex,
  input  logic             branchTaken_Ex,
  input  logic             memReq_Mem,
  input  logic             memAck,
  output logic             pcEn,
  output logic             ifIdEn,
  output logic             ifIdFlush,
  output logic             idExEn,
  output logic             idExFlush,
  output logic             exMemEn,
  output logic             memWbFlush,
  output logic             dmemReq,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt
);

  logic mem_stall;
  logic in_error;
  logic load_use;
  logic branch_eff;
  logic branch_pend_q, branch_pend_d;

  hazard_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (memReq_Mem),
    .mem_ack  (memAck),
    .mem_stall(mem_stall),
    .mem_err  (memErr),
    .in_error (in_error)
  );

  always_comb begin
    load_use = memRead_Ex && (rd_Ex != REG_ZERO) &&
               (src_hit(rs1Used_Id, rs1_Id, rd_Ex) || src_hit(rs2Used_Id, rs2_Id, rd_Ex));
  end

  // A taken branch seen while memory stalls is remembered so the redirect
  // still happens on the release cycle even if EX stops reporting it.
  always_comb begin
    branch_pend_d = mem_stall && (branch_pend_q || branchTaken_Ex);
    branch_eff    = branchTaken_Ex || branch_pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_pend_q <= 1'b0;
    end else begin
      branch_pend_q <= branch_pend_d;
    end
  end

  always_comb begin
    pcEn       = 1'b1;
    ifIdEn     = 1'b1;
    idExEn     = 1'b1;
    exMemEn    = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    memWbFlush = 1'b0;
    dmemReq    = memReq_Mem && !in_error && !rst;
    if (rst) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExEn     = 1'b0;
      exMemEn    = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      memWbFlush = 1'b1;
    end else if (mem_stall) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExEn     = 1'b0;
      exMemEn    = 1'b0;
      memWbFlush = 1'b1;
    end else if (branch_eff) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use) begin
      pcEn      = 1'b0;
      ifIdEn    = 1'b0;
      idExFlush = 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((mem_stall || load_use) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
`else
  assign stallCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 32;

  logic                clk = 1'b0;
  logic                rst;
  regName_t            rs1_Id, rs2_Id, rd_Ex;
  logic                rs1Used_Id, rs2Used_Id, memRead_Ex, branchTaken_Ex, memReq_Mem, memAck;
  logic                pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbFlush;
  logic                dmemReq, memErr;
  logic [TB_CNT_W-1:0] stallCnt;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(TB_TIMEOUT),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_Id        (rs1_Id),
    .rs2_Id        (rs2_Id),
    .rs1Used_Id    (rs1Used_Id),
    .rs2Used_Id    (rs2Used_Id),
    .rd_Ex         (rd_Ex),
    .memRead_Ex    (memRead_Ex),
    .branchTaken_Ex(branchTaken_Ex),
    .memReq_Mem    (memReq_Mem),
    .memAck        (memAck),
    .pcEn          (pcEn),
    .ifIdEn        (ifIdEn),
    .ifIdFlush     (ifIdFlush),
    .idExEn        (idExEn),
    .idExFlush     (idExFlush),
    .exMemEn       (exMemEn),
    .memWbFlush    (memWbFlush),
    .dmemReq       (dmemReq),
    .memErr        (memErr),
    .stallCnt      (stallCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic                dmem_req, mem_err;
    logic [TB_CNT_W-1:0] stall_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model: a pending access, number of wait cycles already spent,
  // a sticky error and a remembered branch.
  bit                  m_waiting;
  int                  m_wait_cycles;
  bit                  m_err;
  bit                  m_branch_held;
  logic [TB_CNT_W-1:0] m_cnt;

  bit cur_rst, cur_stall, cur_lu, cur_br, cur_req, cur_ack;

  task automatic model_reset();
    m_waiting     = 0;
    m_wait_cycles = 0;
    m_err         = 0;
    m_branch_held = 0;
    m_cnt         = '0;
  endtask

  task automatic model_advance();
    if (cur_rst) begin
      model_reset();
    end else begin
      if (!m_err) begin
        if (m_waiting) begin
          if (cur_ack) m_waiting = 0;
          else begin
            m_wait_cycles++;
            if (m_wait_cycles == TB_TIMEOUT) begin
              m_err     = 1;
              m_waiting = 0;
            end
          end
        end else if (cur_req && !cur_ack) begin
          m_waiting     = 1;
          m_wait_cycles = 0;
        end
      end
      m_branch_held = cur_stall && cur_br;
`ifdef HAZARD_STALL_CNT_EN
      if ((cur_stall || cur_lu) && m_cnt != {TB_CNT_W{1'b1}}) m_cnt = m_cnt + 1;
`endif
    end
  endtask

  task automatic applyStimulus(input bit r, input regName_t a, input regName_t b,
                               input bit u1, input bit u2, input regName_t d,
                               input bit mr, input bit br, input bit mq, input bit ak);
    exp_t e;
    bit   lu, stall, br_eff;
    @(posedge clk);
    model_advance();
    #1;
    rst = r; rs1_Id = a; rs2_Id = b; rs1Used_Id = u1; rs2Used_Id = u2;
    rd_Ex = d; memRead_Ex = mr; branchTaken_Ex = br; memReq_Mem = mq; memAck = ak;
    if (r) model_reset();
    lu     = mr && (d != 5'd0) && ((u1 && a == d) || (u2 && b == d));
    stall  = m_err || (!ak && (m_waiting || mq));
    br_eff = br || m_branch_held;
    e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
    e.if_id_flush = 0; e.id_ex_flush = 0; e.mem_wb_flush = 0;
    if (r) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0;
      e.if_id_flush = 1; e.id_ex_flush = 1; e.mem_wb_flush = 1;
    end else if (stall) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0; e.mem_wb_flush = 1;
    end else if (br_eff) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
    end else if (lu) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
    end
    e.dmem_req  = mq && !m_err && !r;
    e.mem_err   = m_err;
    e.stall_cnt = m_cnt;
    exp_q.push_back(e);
    cur_rst = r; cur_stall = stall; cur_lu = lu; cur_br = br_eff; cur_req = mq; cur_ack = ak;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input logic [TB_CNT_W-1:0] act,
                             input logic [TB_CNT_W-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected response per cycle, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pcEn",       {31'd0, pcEn},       {31'd0, e.pc_en});
        checkOutput("ifIdEn",     {31'd0, ifIdEn},     {31'd0, e.if_id_en});
        checkOutput("ifIdFlush",  {31'd0, ifIdFlush},  {31'd0, e.if_id_flush});
        checkOutput("idExEn",     {31'd0, idExEn},     {31'd0, e.id_ex_en});
        checkOutput("idExFlush",  {31'd0, idExFlush},  {31'd0, e.id_ex_flush});
        checkOutput("exMemEn",    {31'd0, exMemEn},    {31'd0, e.ex_mem_en});
        checkOutput("memWbFlush", {31'd0, memWbFlush}, {31'd0, e.mem_wb_flush});
        checkOutput("dmemReq",    {31'd0, dmemReq},    {31'd0, e.dmem_req});
        checkOutput("memErr",     {31'd0, memErr},     {31'd0, e.mem_err});
        checkOutput("stallCnt",   stallCnt,            e.stall_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    cur_rst = 1; cur_stall = 0; cur_lu = 0; cur_br = 0; cur_req = 0; cur_ack = 0;
    rst = 1; rs1_Id = 0; rs2_Id = 0; rs1Used_Id = 0; rs2Used_Id = 0; rd_Ex = 0;
    memRead_Ex = 0; branchTaken_Ex = 0; memReq_Mem = 0; memAck = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs1 then rs2, a bubble between, and rd=x0 immune
    applyStimulus(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 1, 7, 0, 1, 7, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 5, 1, 0, 0, 0);
    // branch beats load-use
    applyStimulus(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    idle(1);
    // 3 wait cycles, a branch seen only in the first stall cycle, then ack
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // zero-wait access
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // timeout into sticky error
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 5, 0, 1, 0, 5, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // reset in the middle of a wait
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    regName_t'($urandom_range(0, 3)), regName_t'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    regName_t'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    idle(1);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Resolves three hazard classes: load-use data hazards, taken-branch control hazards, and variable-latency data-memory accesses (req/ack handshake with timeout).
- Sits beside the datapath; purely a controller, carries no data.

Parameters:
- MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before declaring a memory error (legal range 1..255).
- CNT_W, 32, width of the optional stall counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- rs1_Id  in  regName_t  rs1 of instruction in ID.
- rs2_Id  in  regName_t  rs2 of instruction in ID.
- rs1Used_Id  in  1  ID instruction reads rs1.
- rs2Used_Id  in  1  ID instruction reads rs2.
- rd_Ex  in  regName_t  destination of instruction in EX.
- memRead_Ex  in  1  EX instruction is a load.
- branchTaken_Ex  in  1  branch/jump resolved taken in EX.
- memReq_Mem  in  1  MEM instruction accesses data memory.
- memAck  in  1  data memory completes the access this cycle.
- pcEn  out  1  PC update enable.
- ifIdEn  out  1  IF/ID load enable.
- ifIdFlush  out  1  IF/ID bubble insert.
- idExEn  out  1  ID/EX load enable.
- idExFlush  out  1  ID/EX bubble insert.
- exMemEn  out  1  EX/MEM load enable.
- memWbFlush  out  1  MEM/WB loads bubble (regWrite/memToRegWrite cleared).
- dmemReq  out  1  request to data memory.
- memErr  out  1  sticky memory-timeout error.
- stallCnt  out  CNT_W  stall-cycle count (only with HAZARD_STALL_CNT_EN).

Behaviour:
- Reset: one clock, clk. Asynchronous active-high reset on rst.
  - Reset value: state=RUN, waitCnt=0, memErr=0, stallCnt=0.
  - Combinational outputs while rst is high: pcEn=0, ifIdEn=0, idExEn=0, exMemEn=0, ifIdFlush=1, idExFlush=1, memWbFlush=1, dmemReq=0.
  - Reset mid-MEM_WAIT aborts the access; dmemReq drops immediately.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN -> MEM_WAIT when memReq_Mem & ~memAck.
  - RUN -> RUN when the access is acknowledged in the same cycle (zero-wait access, no stall).
  - MEM_WAIT -> RUN on memAck.
  - MEM_WAIT -> ERROR when waitCnt reaches MEM_TIMEOUT-1 without memAck.
  - ERROR is terminal until rst.
- waitCnt: cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle without memAck.
- memStall = (state==RUN & memReq_Mem & ~memAck) | (state==MEM_WAIT & ~memAck) | state==ERROR. It is combinational, so the stall is visible in the same cycle as the request.
- dmemReq = memReq_Mem & (state!=ERROR).
- loadUse = memRead_Ex & rd_Ex!=zero & ((rs1Used_Id & rs1_Id==rd_Ex) | (rs2Used_Id & rs2_Id==rd_Ex)).
- Priority (highest first):
  - memStall: pcEn=ifIdEn=idExEn=exMemEn=0, no flush on IF/ID or ID/EX, memWbFlush=1. This freezes IF..MEM and prevents duplicate writeback.
  - branchTaken_Ex: all enables 1, ifIdFlush=1, idExFlush=1, memWbFlush=0. A branch taken during memStall is held and takes effect on the release cycle.
  - loadUse: pcEn=0, ifIdEn=0, idExEn=1, idExFlush=1, exMemEn=1. Exactly one bubble per load-use.
  - otherwise: all enables 1, all flushes 0.
- memErr: set on the ERROR transition and held until reset.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - stallCnt increments by 1 each cycle where memStall|loadUse is true (branch flushes not counted).
  - Saturates at all-ones.
  - Resets to 0.
- Undefined: stallCnt port driven constant 0 and no counter flops exist.

Decomposition:
- definitions package:
  - add hazState_t enum {RUN, MEM_WAIT, ERROR};
  - add the MEM_TIMEOUT default constant;
  - reuse regName_t and the zero register name.
- One natural sub-module: hazard_mem_wait_fsm (FSM, waitCnt, memErr, memStall output).
- The load-use and priority logic stays in the top.

Test Plan:
- Load-use: memRead_Ex=1, rd_Ex=x5, rs1_Id=x5, rs1Used_Id=1 -> one cycle of pcEn=0, ifIdEn=0, idExFlush=1. With rd_Ex=zero, no stall.
- Branch: branchTaken_Ex=1 together with loadUse -> ifIdFlush=1, idExFlush=1, pcEn=1 (branch wins).
- Memory wait: memReq_Mem=1, memAck low 3 cycles then high -> memStall asserted 3 cycles with memWbFlush=1; back in RUN on the ack cycle. Zero-wait ack -> no stall.
- Timeout: MEM_TIMEOUT=4, memAck never rises -> ERROR after 4 wait cycles, memErr=1 sticky, dmemReq=0, pipeline frozen.
- Async reset asserted mid-MEM_WAIT -> outputs take reset values immediately; after release, state=RUN and memErr=0.
- With HAZARD_STALL_CNT_EN: 2 load-use stalls plus 3 memory wait cycles -> stallCnt=5. Without the macro -> stallCnt=0.
